// File: rtl/image_ram_pkg.sv
// Shared types and default sizes for the image RAM arbiter slice.
package image_ram_pkg;

  localparam int DEF_ADDR_W    = 14;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_IMG_BYTES = 16384;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  typedef enum logic {
    HOST,
    NPU
  } grant_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: req/grant bit 0 is the host, bit 1 is the NPU.
// last_grant only moves on contention, so a lone requester never steals the
// other's turn.
module rr_arb2
  import image_ram_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  grant_t last_grant;

  // Pick the winner; on contention favour whoever did not win last time.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (last_grant == HOST) ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // Remember the contention winner.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= HOST;
    end else if (en && (req == 2'b11)) begin
      last_grant <= grant[1] ? NPU : HOST;
    end
  end

endmodule

// File: rtl/image_ram_arbiter.sv
// Owns the single image RAM port: auto-addressed host loading, then
// round-robin host/NPU reads with a fixed one-cycle read-data latency.
//
// state | meaning
// IDLE  | no frame, no grants; waits for start_load
// LOAD  | host bytes written to RAM at load_cnt
// RUN   | frame resident; host readback and NPU reads share the port
module image_ram_arbiter
  import image_ram_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int IMG_BYTES = DEF_IMG_BYTES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_load,
  input  logic              host_wr_valid,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic              host_wr_ready,
  input  logic              host_rd_valid,
  input  logic [ADDR_W-1:0] host_rd_addr,
  output logic              host_rd_ready,
  output logic              host_rd_dvalid,
  input  logic              npu_rd_valid,
  input  logic [ADDR_W-1:0] npu_rd_addr,
  output logic              npu_rd_ready,
  output logic              npu_rd_dvalid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              npu_done,
  output logic              frame_ready,
  output logic [ADDR_W:0]   load_cnt,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(IMG_BYTES);

  state_t          state, state_nxt;
  logic [ADDR_W:0] load_cnt_nxt;
  logic            frame_ready_nxt;
  logic [1:0]      grant;
  logic            arb_en;

  // Reads only compete for the port while a frame is resident.
  assign arb_en = (state == RUN) && !reset;

  rr_arb2 u_arb (
    .clock (clock),
    .reset (reset),
    .en    (arb_en),
    .req   ({npu_rd_valid, host_rd_valid}),
    .grant (grant)
  );

  assign host_rd_ready = grant[0];
  assign npu_rd_ready  = grant[1];
  assign rd_data       = ram_q;

  // Next-state, load counter and RAM port steering.
  always_comb begin
    state_nxt       = state;
    load_cnt_nxt    = load_cnt;
    frame_ready_nxt = frame_ready;
    host_wr_ready   = 1'b0;
    ram_address     = '0;
    ram_data        = '0;
    ram_wren        = 1'b0;
    case (state)
      IDLE: begin
        if (start_load) begin
          state_nxt    = LOAD;
          load_cnt_nxt = '0;
        end
      end
      LOAD: begin
        if (start_load) begin
          load_cnt_nxt = '0;
        end else if (host_wr_valid && !reset) begin
          host_wr_ready = 1'b1;
          ram_address   = load_cnt[ADDR_W-1:0];
          ram_data      = host_wr_data;
          ram_wren      = 1'b1;
          load_cnt_nxt  = load_cnt + 1'b1;
          if (load_cnt_nxt == LAST_CNT) begin
            state_nxt       = RUN;
            frame_ready_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (grant[1]) begin
          ram_address = npu_rd_addr;
        end else if (grant[0]) begin
          ram_address = host_rd_addr;
        end
        // A fresh load takes priority over the NPU releasing the frame.
        if (start_load) begin
          state_nxt       = LOAD;
          load_cnt_nxt    = '0;
          frame_ready_nxt = 1'b0;
        end else if (npu_done) begin
          state_nxt       = IDLE;
          frame_ready_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and the read-data-valid pipeline stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      load_cnt       <= '0;
      frame_ready    <= 1'b0;
      host_rd_dvalid <= 1'b0;
      npu_rd_dvalid  <= 1'b0;
    end else begin
      state          <= state_nxt;
      load_cnt       <= load_cnt_nxt;
      frame_ready    <= frame_ready_nxt;
      host_rd_dvalid <= grant[0];
      npu_rd_dvalid  <= grant[1];
    end
  end

endmodule

// File: tb/tb_image_ram_arbiter.sv
// Bench for image_ram_arbiter: RAM model, arbitration model and a read-data
// scoreboard that expects each granted read back exactly one cycle later.
module tb_image_ram_arbiter;

  localparam int AW  = 14;
  localparam int DW  = 8;
  localparam int IMG = 16384;

  logic          clock;
  logic          reset;
  logic          start_load;
  logic          host_wr_valid;
  logic [DW-1:0] host_wr_data;
  logic          host_wr_ready;
  logic          host_rd_valid;
  logic [AW-1:0] host_rd_addr;
  logic          host_rd_ready;
  logic          host_rd_dvalid;
  logic          npu_rd_valid;
  logic [AW-1:0] npu_rd_addr;
  logic          npu_rd_ready;
  logic          npu_rd_dvalid;
  logic [DW-1:0] rd_data;
  logic          npu_done;
  logic          frame_ready;
  logic [AW:0]   load_cnt;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [DW-1:0] ram_q;

  typedef struct {
    bit            who;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mem     [0:IMG-1];
  logic [DW-1:0] ref_mem [0:IMG-1];
  int            checks = 0;
  int            errors = 0;
  bit            exp_run = 0;
  bit            lg = 0;

  image_ram_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .start_load     (start_load),
    .host_wr_valid  (host_wr_valid),
    .host_wr_data   (host_wr_data),
    .host_wr_ready  (host_wr_ready),
    .host_rd_valid  (host_rd_valid),
    .host_rd_addr   (host_rd_addr),
    .host_rd_ready  (host_rd_ready),
    .host_rd_dvalid (host_rd_dvalid),
    .npu_rd_valid   (npu_rd_valid),
    .npu_rd_addr    (npu_rd_addr),
    .npu_rd_ready   (npu_rd_ready),
    .npu_rd_dvalid  (npu_rd_dvalid),
    .rd_data        (rd_data),
    .npu_done       (npu_done),
    .frame_ready    (frame_ready),
    .load_cnt       (load_cnt),
    .ram_address    (ram_address),
    .ram_data       (ram_data),
    .ram_wren       (ram_wren),
    .ram_q          (ram_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port RAM with registered read data.
  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Per-cycle monitor: pop last cycle's expected read, then model this cycle's grant.
  always @(negedge clock) begin
    bit eh, en;
    exp_t e;
    if (reset) begin
      sb.delete();
      lg = 0;
    end else begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("dv_host", 32'(host_rd_dvalid), 32'(e.who == 1'b0));
        chk("dv_npu", 32'(npu_rd_dvalid), 32'(e.who == 1'b1));
        chk("rd_data", 32'(rd_data), 32'(e.data));
      end else begin
        chk("dv_idle", 32'({host_rd_dvalid, npu_rd_dvalid}), 0);
      end
      eh = 0;
      en = 0;
      if (exp_run) begin
        if (host_rd_valid && npu_rd_valid) begin
          if (lg == 0) en = 1; else eh = 1;
          lg = en;
        end else if (host_rd_valid) begin
          eh = 1;
        end else if (npu_rd_valid) begin
          en = 1;
        end
      end
      chk("host_rd_ready", 32'(host_rd_ready), 32'(eh));
      chk("npu_rd_ready", 32'(npu_rd_ready), 32'(en));
      chk("wren_excl", 32'(ram_wren & (host_rd_ready | npu_rd_ready)), 0);
      if (eh) begin
        chk("host_rd_addr", 32'(ram_address), 32'(host_rd_addr));
        sb.push_back('{who: 1'b0, data: ref_mem[host_rd_addr]});
      end
      if (en) begin
        chk("npu_rd_addr", 32'(ram_address), 32'(npu_rd_addr));
        sb.push_back('{who: 1'b1, data: ref_mem[npu_rd_addr]});
      end
    end
  end

  // Caller enters at #1 after a posedge with the DUT in LOAD.
  task automatic do_load(input int n, input int off);
    host_wr_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      host_wr_data = DW'((i + off) & 255);
      @(negedge clock);
      chk("wr_ready", 32'(host_wr_ready), 1);
      chk("wr_en", 32'(ram_wren), 1);
      chk("wr_addr", 32'(ram_address), 32'(i));
      chk("wr_data", 32'(ram_data), 32'(host_wr_data));
      @(posedge clock);
      #1;
      ref_mem[i] = host_wr_data;
    end
    host_wr_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start_load = 0;
    host_wr_valid = 0;
    host_wr_data = '0;
    host_rd_valid = 0;
    host_rd_addr = '0;
    npu_rd_valid = 0;
    npu_rd_addr = '0;
    npu_done = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_frame_ready", 32'(frame_ready), 0);
    chk("rst_load_cnt", 32'(load_cnt), 0);
    chk("rst_dvalid", 32'({host_rd_dvalid, npu_rd_dvalid}), 0);
    chk("rst_ready", 32'({host_wr_ready, host_rd_ready, npu_rd_ready}), 0);
    chk("rst_ram", 32'({ram_wren, ram_address, ram_data}), 0);
    @(posedge clock); #1;
    reset = 0;

    host_wr_valid = 1;
    @(negedge clock);
    chk("idle_wr_ready", 32'(host_wr_ready), 0);
    chk("idle_wren", 32'(ram_wren), 0);
    @(posedge clock); #1;
    host_wr_valid = 0;
    start_load = 1;
    npu_rd_valid = 1;
    npu_rd_addr = 14'h0123;
    @(posedge clock); #1;
    start_load = 0;

    // Full frame with the NPU already requesting throughout the load.
    do_load(IMG, 0);
    exp_run = 1;
    @(negedge clock);
    chk("frame_ready_set", 32'(frame_ready), 1);
    chk("load_cnt_full", 32'(load_cnt), IMG);
    @(posedge clock); #1;
    npu_rd_valid = 0;
    host_rd_valid = 1;
    host_rd_addr = 14'h3FFF;
    @(posedge clock); #1;
    host_rd_valid = 0;
    @(posedge clock); #1;

    // Contention: grants must alternate starting with the NPU.
    host_rd_valid = 1;
    host_rd_addr = 14'd5;
    npu_rd_valid = 1;
    npu_rd_addr = 14'd9;
    repeat (6) @(posedge clock);
    #1;

    // start_load beats npu_done; the read granted now still returns.
    start_load = 1;
    npu_done = 1;
    @(posedge clock); #1;
    start_load = 0;
    npu_done = 0;
    host_rd_valid = 0;
    npu_rd_valid = 0;
    exp_run = 0;
    @(negedge clock);
    chk("restart_frame_ready", 32'(frame_ready), 0);
    chk("restart_load_cnt", 32'(load_cnt), 0);
    @(posedge clock); #1;

    // Partial load then reset.
    do_load(100, 0);
    @(negedge clock);
    chk("load_cnt_100", 32'(load_cnt), 100);
    @(posedge clock); #1;
    reset = 1;
    @(posedge clock);
    @(negedge clock);
    chk("midrst_load_cnt", 32'(load_cnt), 0);
    chk("midrst_frame_ready", 32'(frame_ready), 0);
    chk("midrst_dvalid", 32'({host_rd_dvalid, npu_rd_dvalid}), 0);
    @(posedge clock); #1;
    reset = 0;
    start_load = 1;
    @(posedge clock); #1;
    start_load = 0;
    do_load(1, 8'h77);
    @(negedge clock);
    chk("load_cnt_1", 32'(load_cnt), 1);

    // start_load during LOAD refuses the offered byte and rewinds.
    @(posedge clock); #1;
    start_load = 1;
    host_wr_valid = 1;
    host_wr_data = 8'hEE;
    @(negedge clock);
    chk("restart_wr_ready", 32'(host_wr_ready), 0);
    chk("restart_wren", 32'(ram_wren), 0);
    @(posedge clock); #1;
    start_load = 0;
    host_wr_valid = 0;
    @(negedge clock);
    chk("rewind_load_cnt", 32'(load_cnt), 0);
    @(posedge clock); #1;

    // Second frame, then npu_done releases it.
    do_load(IMG, 1);
    exp_run = 1;
    npu_rd_valid = 1;
    npu_rd_addr = 14'h0123;
    @(posedge clock); #1;
    npu_done = 1;
    @(posedge clock); #1;
    npu_done = 0;
    exp_run = 0;
    @(negedge clock);
    chk("done_frame_ready", 32'(frame_ready), 0);
    @(posedge clock); #1;
    npu_rd_valid = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
